// File: rtl/com_float_encoder.sv
// Iterative encoder from an unsigned integer to the packed {mantissa, exponent}
// float word; normalizes with at most one left shift per clock.
module com_float_encoder #(
  parameter int IN_WIDTH = 16,
  parameter int MANTISSA = 11,
  parameter int EXPONENT = 5,
  parameter int BIAS     = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH-1:0]          in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MANTISSA+EXPONENT-1:0] out_data,
  output logic                         out_zero,
  output logic                         busy,
  output logic [1:0]                   dbg_state
);

  generate
    if (IN_WIDTH < MANTISSA) begin : g_bad_width
      $error("com_float_encoder: IN_WIDTH must be >= MANTISSA");
    end
    if (BIAS < MANTISSA - 1) begin : g_bad_bias_low
      $error("com_float_encoder: BIAS must be >= MANTISSA-1");
    end
    if (BIAS + IN_WIDTH - MANTISSA > (2 ** EXPONENT) - 1) begin : g_bad_bias_high
      $error("com_float_encoder: BIAS + IN_WIDTH - MANTISSA exceeds exponent range");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exponent of an input whose leading one already sits in the MSB.
  localparam int E_INIT_I = BIAS + IN_WIDTH - MANTISSA;
  localparam logic [EXPONENT-1:0] E_INIT = E_INIT_I[EXPONENT-1:0];

  state_t              state;
  logic [IN_WIDTH-1:0] w;
  logic [EXPONENT-1:0] e;
  logic                w_zero;
  logic                w_norm;

  assign w_zero    = (w == '0);
  assign w_norm    = w[IN_WIDTH-1];
  assign dbg_state = state;

  // Handshakes: a word moves on an edge where valid and ready are both high.
  // Input side transfers only in IDLE; output side holds data stable in DONE
  // until out_ready is seen, and out_ready elsewhere has no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      w         <= '0;
      e         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            w        <= in_data;
            e        <= E_INIT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= NORM;
          end
        end
        NORM: begin
          if (w_norm || w_zero) begin
            // Zero encodes as all-zero fields rather than carrying E_INIT.
            out_data  <= w_zero ? '0 : {w[IN_WIDTH-1 -: MANTISSA], e};
            out_zero  <= w_zero;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            w <= {w[IN_WIDTH-2:0], 1'b0};
            e <= e - EXPONENT'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_com_float_encoder.sv
// Directed and randomized bench for com_float_encoder with a queue-based
// scoreboard of {out_zero, out_data} results.
module tb_com_float_encoder;

  localparam int IN_WIDTH = 16;
  localparam int MANTISSA = 11;
  localparam int EXPONENT = 5;
  localparam int BIAS     = 15;
  localparam int OW       = MANTISSA + EXPONENT;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OW-1:0]       out_data;
  logic                out_zero;
  logic                busy;
  logic [1:0]          dbg_state;

  logic [OW:0] exp_q[$];
  int checks;
  int failures;

  com_float_encoder #(
    .IN_WIDTH(IN_WIDTH),
    .MANTISSA(MANTISSA),
    .EXPONENT(EXPONENT),
    .BIAS(BIAS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_zero(out_zero),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: shift count and packed {zero, mantissa, exponent}
  function automatic int shifts_of(input logic [IN_WIDTH-1:0] d);
    logic [IN_WIDTH-1:0] t;
    int s;
    t = d;
    s = 0;
    if (d == '0) return 0;
    while (!t[IN_WIDTH-1]) begin
      t = t << 1;
      s++;
    end
    return s;
  endfunction

  function automatic logic [OW:0] model(input logic [IN_WIDTH-1:0] d);
    logic [IN_WIDTH-1:0] t;
    int s;
    int ex;
    if (d == '0) return {1'b1, {OW{1'b0}}};
    s  = shifts_of(d);
    t  = d << s;
    ex = BIAS + IN_WIDTH - MANTISSA - s;
    return {1'b0, t[IN_WIDTH-1 -: MANTISSA], ex[EXPONENT-1:0]};
  endfunction

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // driver: present one word for exactly one accept edge, then scramble in_data
  task automatic send(input logic [IN_WIDTH-1:0] d);
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(model(d));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = IN_WIDTH'($urandom_range(0, 65535));
    check("accept_busy", {31'd0, busy}, 32'd1);
    check("accept_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  // monitor + scoreboard: latency, result, backpressure hold, release
  task automatic collect(input int exp_lat, input int hold);
    int lat;
    logic [OW:0] exp_v;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      exp_v = '0;
    end else begin
      exp_v = exp_q.pop_front();
    end
    check("out_data", {16'd0, out_data}, {16'd0, exp_v[OW-1:0]});
    check("out_zero", {31'd0, out_zero}, {31'd0, exp_v[OW]});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_data", {16'd0, out_data}, {16'd0, exp_v[OW-1:0]});
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [IN_WIDTH-1:0] d;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed boundary words
    send(16'h8000); collect(1, 0);
    send(16'h0001); collect(16, 0);
    send(16'h07FF); collect(6, 0);
    send(16'hFFFF); collect(1, 0);
    send(16'h0000); collect(1, 0);

    // backpressure with a competing word held on the input
    send(16'h1234);
    in_valid = 1'b1;
    in_data  = 16'h0400;
    collect(shifts_of(16'h1234) + 1, 10);
    check("no_same_cycle_accept", {31'd0, busy}, 32'd0);
    exp_q.push_back(model(16'h0400));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("next_cycle_accept", {31'd0, busy}, 32'd1);
    collect(shifts_of(16'h0400) + 1, 0);

    // out_ready outside DONE must not disturb anything
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_out_ready_valid", {31'd0, out_valid}, 32'd0);
    check("idle_out_ready_in_ready", {31'd0, in_ready}, 32'd1);

    // reset during normalization discards the word
    in_valid = 1'b1;
    in_data  = 16'h0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", {16'd0, out_data}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'h0400); collect(6, 0);

    // randomized words with varying leading-one position and hold time
    for (int k = 0; k < 8; k++) begin
      d = IN_WIDTH'($urandom_range(0, 65535)) >> $urandom_range(0, 15);
      send(d);
      collect(shifts_of(d) + 1, $urandom_range(0, 3));
    end

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
